// File: rtl/casez_match_stage.sv
// Pipelined wildcard classifier with casez semantics: a programmable table of
// label/don't-care/result entries, first-match priority, and result hold on a miss.
module casez_match_stage #(
  parameter int W  = 3,
  parameter int N  = 4,
  parameter int RW = 3,
  parameter int CW = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic          cfg_en,
  input  logic [W-1:0]  cfg_label,
  input  logic [W-1:0]  cfg_dc,
  input  logic [RW-1:0] cfg_result,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_val,
  input  logic [W-1:0]  in_dc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_result,
  output logic          out_hit,
  output logic [IW-1:0] out_idx,
  output logic [CW-1:0] miss_cnt
);

  logic [N-1:0]  en_r;
  logic [W-1:0]  label_r [N];
  logic [W-1:0]  dc_r    [N];
  logic [RW-1:0] res_r   [N];

  logic          valid_a_r;
  logic [N-1:0]  match_a_r;
  logic [RW-1:0] res_a_r [N];
  logic [RW-1:0] held_r;

  logic [N-1:0]  match_s;
  logic          ready_b_s;
  logic          hit_s;
  logic [IW-1:0] idx_s;

  assign ready_b_s = !out_valid | out_ready;
  assign in_ready  = !valid_a_r | ready_b_s;

  // Label table, written one entry per strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r <= '0;
      for (int i = 0; i < N; i++) begin
        label_r[i] <= '0;
        dc_r[i]    <= '0;
        res_r[i]   <= '0;
      end
    end else if (cfg_we) begin
      en_r[cfg_idx]    <= cfg_en;
      label_r[cfg_idx] <= cfg_label;
      dc_r[cfg_idx]    <= cfg_dc;
      res_r[cfg_idx]   <= cfg_result;
    end
  end

  // Per-entry match: every bit is either a don't-care on some side or equal
  always_comb begin
    match_s = '0;
    for (int i = 0; i < N; i++) begin
      match_s[i] = en_r[i] & (&(in_dc | dc_r[i] | ~(in_val ^ label_r[i])));
    end
  end

  // Stage A: capture match vector and result codes as seen at acceptance time,
  // so a later cfg write cannot alter an item already in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_r <= 1'b0;
      match_a_r <= '0;
      for (int i = 0; i < N; i++) res_a_r[i] <= '0;
    end else if (in_ready) begin
      valid_a_r <= in_valid;
      if (in_valid) begin
        match_a_r <= match_s;
        for (int i = 0; i < N; i++) res_a_r[i] <= res_r[i];
      end
    end
  end

  // Lowest set bit of the match vector wins; loop runs downward so it overwrites last
  always_comb begin
    hit_s = |match_a_r;
    idx_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (match_a_r[i]) idx_s = IW'(i);
      else              idx_s = idx_s;
    end
  end

  // Stage B: register result, update held value and miss counter once per item
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_hit    <= 1'b0;
      out_idx    <= '0;
      out_result <= '0;
      held_r     <= '0;
      miss_cnt   <= '0;
    end else if (ready_b_s) begin
      out_valid <= valid_a_r;
      if (valid_a_r) begin
        out_hit <= hit_s;
        if (hit_s) begin
          out_idx    <= idx_s;
          out_result <= res_a_r[idx_s];
          held_r     <= res_a_r[idx_s];
        end else begin
          out_idx    <= '0;
          out_result <= held_r;
          if (miss_cnt != {CW{1'b1}}) miss_cnt <= miss_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_casez_match_stage.sv
// Directed bench for casez_match_stage: a table-lookup model predicts every
// delivered result, plus literal checks pinning the documented scenarios.
module tb_casez_match_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic       cfg_en = 1'b0;
  logic [2:0] cfg_label = '0, cfg_dc = '0, cfg_result = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_val = '0, in_dc = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_result;
  logic       out_hit;
  logic [1:0] out_idx;
  logic [7:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  casez_match_stage #(.W(3), .N(4), .RW(3), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_label(cfg_label),
    .cfg_dc(cfg_dc), .cfg_result(cfg_result),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_dc(in_dc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_hit(out_hit), .out_idx(out_idx), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: table contents plus a queue of predicted outputs
  typedef struct { int hit; int idx; int res; int miss; } exp_t;
  exp_t exp_q[$];
  int m_en[4], m_lab[4], m_dc[4], m_res[4];
  int m_held = 0, m_miss = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_held = 0; m_miss = 0;
      for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_lab[i] = 0; m_dc[i] = 0; m_res[i] = 0; end
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        int win;
        win = -1;
        for (int i = 0; i < 4; i++) begin
          bit ok;
          ok = (m_en[i] != 0);
          for (int b = 0; b < 3; b++)
            if (!(in_dc[b] || ((m_dc[i] >> b) & 1) != 0 || in_val[b] == ((m_lab[i] >> b) & 1)))
              ok = 0;
          if (ok && win < 0) win = i;
        end
        if (win >= 0) begin
          m_held = m_res[win];
          e.hit = 1; e.idx = win; e.res = m_res[win];
        end else begin
          if (m_miss < 255) m_miss++;
          e.hit = 0; e.idx = 0; e.res = m_held;
        end
        e.miss = m_miss;
        exp_q.push_back(e);
      end
      if (cfg_we) begin
        m_en[cfg_idx] = cfg_en; m_lab[cfg_idx] = cfg_label;
        m_dc[cfg_idx] = cfg_dc; m_res[cfg_idx] = cfg_result;
      end
    end
  end

  // Compare process: every visible result against the model, and stability while stalled
  bit prev_stall = 0;
  int prev_res, prev_hit, prev_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      check("reset_out_valid", out_valid, 0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("model_hit", out_hit, exp_q[0].hit);
        check("model_idx", out_idx, exp_q[0].idx);
        check("model_result", out_result, exp_q[0].res);
        check("model_miss_cnt", miss_cnt, exp_q[0].miss);
        if (prev_stall) begin
          check("stall_result_stable", out_result, prev_res);
          check("stall_hit_stable", out_hit, prev_hit);
          check("stall_idx_stable", out_idx, prev_idx);
        end
        prev_stall = !out_ready;
        prev_res = out_result; prev_hit = out_hit; prev_idx = out_idx;
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic cfg(input int idx, input int en, input int lab, input int dc, input int res);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en[0];
    cfg_label = 3'(lab); cfg_dc = 3'(dc); cfg_result = 3'(res);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input int v, input int d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_val = 3'(v); in_dc = 3'(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input int hit, input int idx, input int res);
    bit seen;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_hit"}, out_hit, hit);
      check({name, "_idx"}, out_idx, idx);
      check({name, "_result"}, out_result, res);
    end
  endtask

  // Caller is at posedge+1; holds the item until it is accepted
  int accepted_before_stall;
  int n_pushed;
  task automatic push_item(input int v, input int d);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_val = 3'(v); in_dc = 3'(d);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok && accepted_before_stall < 0) accepted_before_stall = n_pushed;
      @(posedge clk); #1;
    end
    if (!ok) check("push_timeout", 0, 1);
    n_pushed++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_hit", out_hit, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_result", out_result, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    cfg(0, 1, 3'b000, 3'b000, 0);
    cfg(1, 1, 3'b010, 3'b000, 1);
    cfg(2, 1, 3'b110, 3'b000, 2);
    send(3'b000, 3'b010);
    expect_out("t1", 1, 0, 0);
    send(3'b010, 3'b001);
    expect_out("t2", 1, 1, 1);
    send(3'b111, 3'b000);
    expect_out("t3_miss", 0, 0, 1);
    check("t3_miss_cnt", miss_cnt, 1);

    cfg(0, 1, 3'b100, 3'b010, 5);
    cfg(1, 0, 0, 0, 0);
    cfg(2, 0, 0, 0, 0);
    cfg(3, 1, 3'b110, 3'b000, 6);
    send(3'b110, 3'b000);
    expect_out("overlap", 1, 0, 5);
    cfg(0, 0, 3'b100, 3'b010, 5);
    send(3'b110, 3'b000);
    expect_out("overlap_dis", 1, 3, 6);
    send(3'b000, 3'b111);
    expect_out("all_dc", 1, 3, 6);

    // Same-cycle write of entry 3 and acceptance: item sees old contents
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_en = 1'b0; cfg_label = 3'b110; cfg_dc = '0; cfg_result = 3'd6;
    in_valid = 1'b1; in_val = 3'b110; in_dc = 3'b000;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    expect_out("simul_old", 1, 3, 6);
    send(3'b110, 3'b000);
    expect_out("simul_new", 0, 0, 6);
    check("simul_miss_cnt", miss_cnt, 2);

    // Backpressure: four items back-to-back with the consumer stalled
    cfg(1, 1, 3'b001, 3'b010, 3);
    out_ready = 1'b0;
    accepted_before_stall = -1;
    n_pushed = 0;
    @(posedge clk); #1;
    fork
      begin
        push_item(3'b001, 0);
        push_item(3'b111, 0);
        push_item(3'b011, 0);
        push_item(3'b000, 0);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_accept_before_stall", accepted_before_stall, 2);
    repeat (6) @(negedge clk);
    check("bp_drained", exp_q.size(), 0);
    check("bp_miss_cnt", miss_cnt, 4);

    // Saturation of the miss counter
    @(posedge clk); #1;
    repeat (300) push_item(3'b111, 0);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_miss_cnt", miss_cnt, 255);

    // Reset with items in flight
    @(posedge clk); #1;
    push_item(3'b111, 0);
    push_item(3'b111, 0);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_miss_cnt", miss_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    send(3'b001, 3'b000);
    expect_out("post_rst", 0, 0, 0);
    check("post_rst_miss_cnt", miss_cnt, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
